// File: rtl/ascon_pack.sv
// Shared ASCON types: the 5x64 permutation state and its word count.
package ascon_pack;
    localparam int NB_STATE_WORDS = 5;

    typedef logic [NB_STATE_WORDS-1:0][63:0] type_state;
endpackage

// File: rtl/state_loader.sv
// Assembles five 64-bit words into a 320-bit ASCON state, then pulses the
// state register enable for one cycle so the register captures state_o.
module state_loader
    import ascon_pack::*;
#(
    parameter bit REVERSE_ORDER = 1'b0
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [63:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output type_state   state_o,
    output logic        en_reg_state_o,
    output logic        busy_o,
    output logic [2:0]  word_cnt_o
);
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} fsm_t;

    localparam logic [2:0] LAST_WORD = 3'(NB_STATE_WORDS - 1);

    fsm_t       fsm, fsm_next;
    logic [2:0] word_cnt, word_cnt_next;
    type_state  state_q;
    logic       hs;
    logic [2:0] wr_idx;

    // Abort wins over a word offered in the same cycle.
    assign ready_o = (fsm == LOAD) && !abort_i;
    assign hs      = valid_i && ready_o;
    assign wr_idx  = REVERSE_ORDER ? (LAST_WORD - word_cnt) : word_cnt;

    always_comb begin
        fsm_next       = fsm;
        word_cnt_next  = word_cnt;
        en_reg_state_o = 1'b0;
        busy_o         = 1'b0;
        case (fsm)
            IDLE: begin
                if (start_i && !abort_i) begin
                    fsm_next      = LOAD;
                    word_cnt_next = 3'd0;
                end
            end
            LOAD: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    fsm_next      = IDLE;
                    word_cnt_next = 3'd0;
                end else if (hs) begin
                    word_cnt_next = word_cnt + 3'd1;
                    if (word_cnt == LAST_WORD)
                        fsm_next = COMMIT;
                end
            end
            COMMIT: begin
                busy_o         = 1'b1;
                en_reg_state_o = 1'b1;
                fsm_next       = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm      <= IDLE;
            word_cnt <= 3'd0;
            state_q  <= '0;
        end else begin
            fsm      <= fsm_next;
            word_cnt <= word_cnt_next;
            if (hs)
                state_q[wr_idx] <= data_i;
        end
    end

    assign state_o    = state_q;
    assign word_cnt_o = word_cnt;
endmodule

// File: tb/tb_state_loader.sv
// Random and directed stimulus for both word orders, checked against a
// transaction-level model of the loader.
module tb_state_loader;
    import ascon_pack::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, valid;
    logic [63:0] data;

    logic        ready_f, en_f, busy_f, ready_r, en_r, busy_r;
    logic [2:0]  cnt_f, cnt_r;
    type_state   st_f, st_r;

    int n_tests = 0;
    int n_fail  = 0;

    // model
    bit        m_loading, m_commit;
    int        m_cnt;
    type_state m_fwd, m_rev;

    always #5 clk = ~clk;

    state_loader #(.REVERSE_ORDER(1'b0)) dut_f (
        .clock_i(clk), .reset_i(rst), .start_i(start), .abort_i(abort),
        .data_i(data), .valid_i(valid), .ready_o(ready_f), .state_o(st_f),
        .en_reg_state_o(en_f), .busy_o(busy_f), .word_cnt_o(cnt_f)
    );

    state_loader #(.REVERSE_ORDER(1'b1)) dut_r (
        .clock_i(clk), .reset_i(rst), .start_i(start), .abort_i(abort),
        .data_i(data), .valid_i(valid), .ready_o(ready_r), .state_o(st_r),
        .en_reg_state_o(en_r), .busy_o(busy_r), .word_cnt_o(cnt_r)
    );

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_loading = 0;
        m_commit  = 0;
        m_cnt     = 0;
        m_fwd     = '0;
        m_rev     = '0;
    endtask

    task automatic check_all(input string tag);
        bit exp_ready;
        exp_ready = m_loading && !abort;
        chk({tag, ".ready_f"}, 320'(ready_f), 320'(exp_ready));
        chk({tag, ".ready_r"}, 320'(ready_r), 320'(exp_ready));
        chk({tag, ".en_f"},    320'(en_f),    320'(m_commit));
        chk({tag, ".en_r"},    320'(en_r),    320'(m_commit));
        chk({tag, ".busy_f"},  320'(busy_f),  320'(m_loading || m_commit));
        chk({tag, ".busy_r"},  320'(busy_r),  320'(m_loading || m_commit));
        chk({tag, ".cnt_f"},   320'(cnt_f),   320'(m_cnt));
        chk({tag, ".cnt_r"},   320'(cnt_r),   320'(m_cnt));
        chk({tag, ".st_f"},    st_f,          m_fwd);
        chk({tag, ".st_r"},    st_r,          m_rev);
    endtask

    // One clock: drive inputs, check outputs, then advance the model.
    task automatic cycle(input string tag, input bit s, input bit a, input bit v,
                         input logic [63:0] d);
        @(negedge clk);
        start = s; abort = a; valid = v; data = d;
        #1;
        check_all(tag);
        @(posedge clk);
        if (m_commit) begin
            m_commit = 0;
        end else if (m_loading) begin
            if (a) begin
                m_loading = 0;
                m_cnt     = 0;
            end else if (v) begin
                m_fwd[m_cnt]     = d;
                m_rev[4 - m_cnt] = d;
                m_cnt++;
                if (m_cnt == NB_STATE_WORDS) begin
                    m_loading = 0;
                    m_commit  = 1;
                end
            end
        end else if (s && !a) begin
            m_loading = 1;
            m_cnt     = 0;
        end
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        start = 0; abort = 0; valid = 0;
        rst = 1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 0;
    endtask

    logic [63:0] words [5];

    initial begin
        words[0] = 64'h0123456789ABCDEF;
        words[1] = 64'h1111111111111111;
        words[2] = 64'h2222222222222222;
        words[3] = 64'h3333333333333333;
        words[4] = 64'h4444444444444444;
        rst = 1; start = 0; abort = 0; valid = 0; data = '0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 0;

        // back-to-back load, valid held high from the start cycle
        cycle("ld_start", 1, 0, 1, 64'hDEAD);
        for (int i = 0; i < 5; i++) cycle("ld_word", 0, 0, 1, words[i]);
        cycle("ld_commit", 0, 0, 1, 64'hBEEF);
        chk("ld_en_cycle6", 320'(en_f), 320'(1'b1));
        for (int i = 0; i < 5; i++) begin
            chk("ld_fwd_word", 320'(st_f[i]), 320'(words[i]));
            chk("ld_rev_word", 320'(st_r[4 - i]), 320'(words[i]));
        end
        cycle("ld_idle", 0, 0, 0, '0);
        chk("ld_cnt_hold5", 320'(cnt_f), 320'(3'd5));

        // stall three cycles after the second word
        cycle("st_start", 1, 0, 0, '0);
        for (int i = 0; i < 2; i++) cycle("st_word", 0, 0, 1, 64'hA0 + 64'(i));
        for (int i = 0; i < 3; i++) begin
            cycle("st_stall", 0, 0, 0, '0);
            chk("st_cnt2", 320'(cnt_f), 320'(3'd2));
        end
        for (int i = 2; i < 5; i++) cycle("st_word", 0, 0, 1, 64'hA0 + 64'(i));
        cycle("st_commit", 0, 1, 0, '0);   // abort in COMMIT ignored
        chk("st_en_delayed", 320'(en_f), 320'(1'b1));

        // abort after three words with a word offered
        cycle("ab_start", 1, 0, 0, '0);
        for (int i = 0; i < 3; i++) cycle("ab_word", 0, 0, 1, 64'hC0 + 64'(i));
        cycle("ab_abort", 0, 1, 1, 64'hFFFF);
        for (int i = 0; i < 3; i++) cycle("ab_after", 0, 0, 1, '0);
        chk("ab_cnt0", 320'(cnt_f), 320'(3'd0));
        chk("ab_w3_kept", 320'(st_f[3]), 320'(64'hA3));
        chk("ab_w4_kept", 320'(st_f[4]), 320'(64'hA4));

        // start with abort in IDLE; start during LOAD
        cycle("sa_idle", 1, 1, 0, '0);
        cycle("sa_check", 0, 0, 0, '0);
        cycle("sl_start", 1, 0, 1, '0);
        cycle("sl_w0", 0, 0, 1, 64'hE0);
        cycle("sl_w1", 1, 0, 1, 64'hE1);
        cycle("sl_check", 1, 0, 0, '0);
        chk("sl_cnt_not_cleared", 320'(cnt_f), 320'(3'd2));

        // asynchronous reset during word 4
        cycle("rs_w2", 0, 0, 1, 64'hE2);
        cycle("rs_w3", 0, 0, 1, 64'hE3);
        async_reset("rs_async");
        for (int i = 0; i < 4; i++) cycle("rs_after", 0, 0, 1, 64'h55);

        // random
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0)
                async_reset("rnd_reset");
            else
                cycle("rnd", $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 3) != 0, {$urandom, $urandom});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/state_loader.md
STATE_LOADER -- requirements
Module: state_loader

Interface
Parameters:
REQ-001 The block SHALL have parameter REVERSE_ORDER, default 0: 0 = first accepted word to state_o[0], 1 = first accepted word to state_o[4].

Ports:
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clock_i  in  1  sole clock, rising edge.
REQ-004 reset_i  in  1  asynchronous active-high reset.
REQ-005 start_i  in  1  single-cycle request to begin assembling a new 320-bit state.
REQ-006 abort_i  in  1  cancels an assembly in progress.
REQ-007 data_i  in  64  incoming state word.
REQ-008 valid_i  in  1  data_i is valid.
REQ-009 ready_o  out  1  block accepts data_i this cycle.
REQ-010 state_o  out  type_state  assembled 5x64 state, drives the state register's state input.
REQ-011 en_reg_state_o  out  1  single-cycle pulse, drives the state register's enable.
REQ-012 busy_o  out  1  high in LOAD and COMMIT.
REQ-013 word_cnt_o  out  3  words accepted in the current assembly, 0..5.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, LOAD, COMMIT.
REQ-015 In IDLE, start_i=1 with abort_i=0 SHALL move to LOAD and clear word_cnt_o to 0.
REQ-016 ready_o SHALL equal (state==LOAD) AND NOT abort_i, and SHALL be 0 in IDLE and COMMIT.
REQ-017 A handshake occurs when valid_i=1 and ready_o=1; the block SHALL write data_i into word index word_cnt_o (or 4-word_cnt_o if REVERSE_ORDER=1) and increment word_cnt_o.
REQ-018 On the handshake taking word_cnt_o from 4 to 5, the FSM SHALL move to COMMIT.
REQ-019 In COMMIT, en_reg_state_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 en_reg_state_o SHALL be 0 in every other cycle.
REQ-021 Latency: with start_i at cycle 0 and valid_i held high, words SHALL be accepted at cycles 1-5 and en_reg_state_o SHALL be high at cycle 6.
REQ-022 state_o SHALL hold the complete new state in the en_reg_state_o cycle, and SHALL remain unchanged until the next handshake.
REQ-023 Unwritten words SHALL keep their previous values; no word SHALL be written outside a handshake.
REQ-024 start_i in LOAD or COMMIT SHALL be ignored.
REQ-025 abort_i in LOAD SHALL return the FSM to IDLE next cycle, clear word_cnt_o, and produce no en_reg_state_o pulse; the word presented that cycle SHALL NOT be accepted.
REQ-026 abort_i in IDLE SHALL override a simultaneous start_i, and the FSM SHALL stay in IDLE.
REQ-027 abort_i in COMMIT SHALL be ignored; the pulse SHALL still occur.
REQ-028 valid_i stalls (valid_i=0) in LOAD SHALL hold the FSM and word_cnt_o indefinitely.
REQ-029 word_cnt_o SHALL hold 5 during COMMIT and SHALL keep that value in IDLE until the next start.

Reset
REQ-030 While reset_i=1, the block SHALL immediately force: FSM=IDLE, state_o all words 64'h0, word_cnt_o=0, en_reg_state_o=0, ready_o=0, busy_o=0.
REQ-031 Reset asserted mid-LOAD or in COMMIT SHALL discard the partial state with no en_reg_state_o pulse.
REQ-032 After reset deassertion, the block SHALL require a fresh start_i.

Structure
REQ-033 type_state and a new constant NB_STATE_WORDS=5 SHALL reside in ascon_pack.
REQ-034 The FSM state enum SHALL be local to the module.
REQ-035 The design SHALL be a single module with no sub-module; outputs pair directly with the state register's state/enable inputs at the top level.

Verification
REQ-036 Reset then load: start, words 64'h0123456789ABCDEF, 64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333, 64'h4444444444444444 back-to-back -> en_reg_state_o high at cycle 6 only; state_o[0..4] in that order.
REQ-037 REVERSE_ORDER=1, same words -> state_o[4]=64'h0123456789ABCDEF, state_o[0]=64'h4444444444444444.
REQ-038 Stall: valid_i low for 3 cycles after the second word -> word_cnt_o holds 2, pulse delayed by exactly 3 cycles.
REQ-039 Abort after 3 words, with valid_i=1 in the abort cycle -> no pulse, word_cnt_o=0, words 3-4 unchanged, ready_o=0 in the abort cycle.
REQ-040 Reset asserted asynchronously mid-cycle during word 4 -> outputs 0 immediately, state_o all zero, no pulse after release.
REQ-041 start_i with abort_i in IDLE, and start_i during LOAD -> FSM stays IDLE or unaffected, respectively; word_cnt_o is not cleared in LOAD.
